// File: rtl/fifo_pkg.sv
// Shared constants and pointer arithmetic for the AXI-Stream synchronous FIFO.
// Holds the default parameter values and the wrap-aware occupancy helper.
package fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH    = 8;
    localparam int unsigned DEF_DEPTH         = 128;
    localparam int unsigned DEF_AFULL_MARGIN  = 4;    // almost-full sits this far below DEPTH
    localparam int unsigned DEF_AEMPTY_THRESH = 4;
    localparam int unsigned PTR_CALC_W        = 32;   // widest pointer the helper handles

    // Occupancy from two wrap-bit pointers: (wr - rd) mod 2^ptr_w.
    function automatic logic [PTR_CALC_W-1:0] ptr_count(
        input logic [PTR_CALC_W-1:0] wr_ptr,
        input logic [PTR_CALC_W-1:0] rd_ptr,
        input int unsigned           ptr_w
    );
        logic [PTR_CALC_W-1:0] mask;
        mask = (PTR_CALC_W'(1) << ptr_w) - PTR_CALC_W'(1);
        return (wr_ptr - rd_ptr) & mask;
    endfunction

endpackage

// File: rtl/axis_sync_fifo_if.sv
// AXI-Stream producer/consumer bundle around the FIFO.
// slave  : FIFO view (accepts s_axis_*, drives m_axis_*).
// master : environment view (drives s_axis_*, accepts m_axis_*).
interface axis_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] s_axis_fifo_data;
    logic                  s_axis_fifo_valid;
    logic                  s_axis_fifo_ready;
    logic [DATA_WIDTH-1:0] m_axis_fifo_data;
    logic                  m_axis_fifo_data_valid;
    logic                  m_axis_fifo_data_ready;

    modport slave (
        input  s_axis_fifo_data,
        input  s_axis_fifo_valid,
        output s_axis_fifo_ready,
        output m_axis_fifo_data,
        output m_axis_fifo_data_valid,
        input  m_axis_fifo_data_ready
    );

    modport master (
        output s_axis_fifo_data,
        output s_axis_fifo_valid,
        input  s_axis_fifo_ready,
        input  m_axis_fifo_data,
        input  m_axis_fifo_data_valid,
        output m_axis_fifo_data_ready
    );

endinterface

// File: rtl/axis_fifo_ptr_ctrl.sv
// Pointer controller for the synchronous FIFO: wrap-bit read/write pointers,
// push/pop qualification, flush/reset, and full/empty/count/almost flags.
// Ports: clk, reset (async, active-high), flush, s_valid, m_ready in;
//        wr_addr, rd_addr, push_c, s_ready, m_valid, full, empty,
//        almost_full, almost_empty, count out.
// Build option: AXIS_SYNC_FIFO_ALMOST_FLAGS_EN enables threshold almost-flags;
// otherwise almost_full/almost_empty mirror full/empty.
module axis_fifo_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned PTR_SIZE      = $clog2(DEPTH),
    parameter int unsigned AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                s_valid,
    input  logic                m_ready,
    output logic [PTR_SIZE-1:0] wr_addr,
    output logic [PTR_SIZE-1:0] rd_addr,
    output logic                push_c,
    output logic                s_ready,
    output logic                m_valid,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [PTR_SIZE:0]   count
);

    localparam int unsigned PTR_W = PTR_SIZE + 1;

    typedef logic [PTR_SIZE:0] ptr_t;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    logic pop_c;

    // Status derived purely from the registered pointers.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_SIZE] != rd_ptr_q[PTR_SIZE]) &&
                     (wr_ptr_q[PTR_SIZE-1:0] == rd_ptr_q[PTR_SIZE-1:0]);
    assign count   = PTR_W'(ptr_count(PTR_CALC_W'(wr_ptr_q), PTR_CALC_W'(rd_ptr_q), PTR_W));
    assign s_ready = !full;
    assign m_valid = !empty;
    assign push_c  = s_valid && s_ready;
    assign pop_c   = m_valid && m_ready;
    assign wr_addr = wr_ptr_q[PTR_SIZE-1:0];
    assign rd_addr = rd_ptr_q[PTR_SIZE-1:0];

`ifdef AXIS_SYNC_FIFO_ALMOST_FLAGS_EN
    if (AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("AFULL_THRESH must not exceed DEPTH");
    end
    if (AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
        $error("AEMPTY_THRESH must be below DEPTH");
    end

    assign almost_full  = (count >= PTR_W'(AFULL_THRESH));
    assign almost_empty = (count <= PTR_W'(AEMPTY_THRESH));
`else
    // Thresholds have no effect in this build; kept so both builds share parameters.
    localparam int unsigned unused_thresh = AFULL_THRESH + AEMPTY_THRESH;

    assign almost_full  = full;
    assign almost_empty = empty;
`endif

    // Next pointers: flush wins over any push/pop in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through AXI-Stream FIFO.
// Ports: clk, reset (async, active-high), flush (sync clear),
//        axis (slave modport: s_axis_fifo_* in, m_axis_fifo_* out),
//        full, empty, almost_full, almost_empty, count (0..DEPTH).
// Build option: AXIS_SYNC_FIFO_ALMOST_FLAGS_EN selects threshold-based
// almost-flags (AFULL_THRESH / AEMPTY_THRESH); otherwise they equal full/empty.
module axis_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned DEPTH         = DEF_DEPTH,
    parameter int unsigned PTR_SIZE      = $clog2(DEPTH),
    parameter int unsigned AFULL_THRESH  = DEPTH - DEF_AFULL_MARGIN,
    parameter int unsigned AEMPTY_THRESH = DEF_AEMPTY_THRESH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    axis_sync_fifo_if.slave     axis,
    output logic                full,
    output logic                empty,
    output logic                almost_full,
    output logic                almost_empty,
    output logic [PTR_SIZE:0]   count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if ((1 << PTR_SIZE) != DEPTH) begin : g_bad_ptr_size
        $error("PTR_SIZE must equal clog2(DEPTH)");
    end

    logic [PTR_SIZE-1:0]   wr_addr;
    logic [PTR_SIZE-1:0]   rd_addr;
    logic                  push_c;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    axis_fifo_ptr_ctrl #(
        .DEPTH         (DEPTH),
        .PTR_SIZE      (PTR_SIZE),
        .AFULL_THRESH  (AFULL_THRESH),
        .AEMPTY_THRESH (AEMPTY_THRESH)
    ) u_ptr_ctrl (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .s_valid      (axis.s_axis_fifo_valid),
        .m_ready      (axis.m_axis_fifo_data_ready),
        .wr_addr      (wr_addr),
        .rd_addr      (rd_addr),
        .push_c       (push_c),
        .s_ready      (axis.s_axis_fifo_ready),
        .m_valid      (axis.m_axis_fifo_data_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    // Storage is never reset or flushed; only the pointers define contents.
    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_addr] <= axis.s_axis_fifo_data;
    end

    // Fall-through head: the write port never targets rd_addr while not empty.
    assign axis.m_axis_fifo_data = mem_q[rd_addr];

endmodule

// File: tb/tb_axis_sync_fifo.sv
// Randomised self-checking bench for axis_sync_fifo against a queue model.
module tb_axis_sync_fifo;

    localparam int unsigned DW     = 8;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned PTR_SZ = 3;
    localparam int unsigned AFULL  = 6;
    localparam int unsigned AEMPTY = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              full, empty, almost_full, almost_empty;
    logic [PTR_SZ:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] model_q[$];

    axis_sync_fifo_if #(.DATA_WIDTH(DW)) bus ();

    axis_sync_fifo #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .PTR_SIZE      (PTR_SZ),
        .AFULL_THRESH  (AFULL),
        .AEMPTY_THRESH (AEMPTY)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .axis         (bus),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT status output with what the queue model implies.
    task automatic check_state(input string tag);
        int n;
        n = model_q.size();
        check({tag, ".count"}, 32'(count), 32'(n));
        check({tag, ".empty"}, 32'(empty), 32'(n == 0));
        check({tag, ".full"},  32'(full),  32'(n == DEPTH));
        check({tag, ".ready"}, 32'(bus.s_axis_fifo_ready), 32'(n != DEPTH));
        check({tag, ".valid"}, 32'(bus.m_axis_fifo_data_valid), 32'(n != 0));
`ifdef AXIS_SYNC_FIFO_ALMOST_FLAGS_EN
        check({tag, ".afull"},  32'(almost_full),  32'(n >= AFULL));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AEMPTY));
`else
        check({tag, ".afull"},  32'(almost_full),  32'(n == DEPTH));
        check({tag, ".aempty"}, 32'(almost_empty), 32'(n == 0));
`endif
        if (n != 0) check({tag, ".data"}, 32'(bus.m_axis_fifo_data), 32'(model_q[0]));
    endtask

    // One clock: model applies the handshake seen at the edge, then compare.
    task automatic step(input string tag);
        bit           do_push, do_pop;
        logic [DW-1:0] din;
        do_push = bus.s_axis_fifo_valid && (model_q.size() < DEPTH);
        do_pop  = bus.m_axis_fifo_data_ready && (model_q.size() > 0);
        din     = bus.s_axis_fifo_data;
        @(posedge clk);
        if (flush) begin
            model_q.delete();
        end else begin
            if (do_pop)  void'(model_q.pop_front());
            if (do_push) model_q.push_back(din);
        end
        #1;
        check_state(tag);
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic r);
        bus.s_axis_fifo_valid      = v;
        bus.s_axis_fifo_data       = d;
        bus.m_axis_fifo_data_ready = r;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 1'b0);
        #22;
        reset = 1'b0;
        #1;
        check_state("reset");

        // Fill to full with downstream stalled, then hold a 9th beat.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, DW'(i), 1'b0);
            step("fill");
        end
        drive(1'b1, 8'h09, 1'b0);
        step("hold9");
        step("hold9b");

        // Pop while full: ready rises only after the edge; the 9th beat is not taken then.
        drive(1'b1, 8'h09, 1'b1);
        check("full_pop.ready_pre", 32'(bus.s_axis_fifo_ready), 32'd0);
        step("full_pop");
        check("full_pop.count", 32'(count), 32'd7);
        drive(1'b1, 8'h09, 1'b0);
        step("push9");

        // Drain everything in order.
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step("drain");
        check("drain.empty", 32'(empty), 32'd1);

        // Three resident, then simultaneous push/pop across a pointer wrap.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, DW'(8'h30 + i), 1'b0);
            step("prime3");
        end
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, DW'(8'h40 + i), 1'b1);
            step("stream3");
            check("stream3.count3", 32'(count), 32'd3);
        end
        drive(1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) step("drain3");

        // Single beat into empty FIFO, then a stalled head while more beats arrive.
        drive(1'b1, 8'hA5, 1'b0);
        step("a5");
        check("a5.valid", 32'(bus.m_axis_fifo_data_valid), 32'd1);
        check("a5.data", 32'(bus.m_axis_fifo_data), 32'hA5);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, DW'($urandom_range(255)), 1'b0);
            step("stall");
            check("stall.data", 32'(bus.m_axis_fifo_data), 32'hA5);
            check("stall.valid", 32'(bus.m_axis_fifo_data_valid), 32'd1);
        end

        // Flush with a concurrent push and pop pending.
        drive(1'b1, 8'h77, 1'b1);
        flush = 1'b1;
        step("flush");
        flush = 1'b0;
        check("flush.count0", 32'(count), 32'd0);

        // Random traffic with occasional flush.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(9) < 7), DW'($urandom_range(255)),
                  1'($urandom_range(9) < 5));
            flush = 1'($urandom_range(59) == 0);
            step("rand");
        end
        flush = 1'b0;

        // Build up a few entries, then reset asynchronously mid-transfer.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, DW'(8'hC0 + i), 1'b0);
            step("preburst");
        end
        drive(1'b1, 8'hEE, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        model_q.delete();
        check_state("async_reset");
        #2;
        reset = 1'b0;
        drive(1'b0, '0, 1'b0);
        step("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
